noc2_msg_deframer: RTL and testbench
====================================

Name: noc2_msg_deframer

Overview:
- Downstream consumer of the L2's NoC2 output (noc2_valid_out / noc2_data_out / noc2_ready_out).
- Reassembles one multi-flit NoC2 message (header + payload flits) into a single parallel message record.
- Presents the record on a valid/ready interface to the ILA-comparison side of the verification wrapper, which checks decoded msg2 type/valid against the ILA.
- Holds exactly one message; backpressures the L2 while that message is unconsumed.

Parameters:
- FLIT_W, 64, NoC flit width in bits.
- MAX_PAYLOAD, 4, payload flits stored per message (1..8).
- CNT_W, 16, width of the completed-message counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- noc_valid_in  in  1  flit valid from L2 noc2_valid_out.
- noc_data_in  in  FLIT_W  flit from L2 noc2_data_out.
- noc_ready_out  out  1  drives L2 noc2_ready_out.
- msg_valid  out  1  assembled message available.
- msg_ready  in  1  consumer accepts message.
- msg_type  out  8  header[21:14].
- msg_mshrid  out  8  header[13:6].
- msg_len  out  8  header[29:22], payload flit count.
- msg_chipid  out  14  header[63:50].
- msg_x  out  8  header[49:42].
- msg_y  out  8  header[41:34].
- msg_payload  out  MAX_PAYLOAD*FLIT_W  payload flit i at [i*FLIT_W +: FLIT_W].
- msg_count  out  CNT_W  messages delivered since reset.
- err  out  1  sticky protocol error.

Behaviour:
- Flit transfer occurs when noc_valid_in && noc_ready_out in the same cycle.
- FSM states: IDLE, PAYLOAD, HOLD.
- IDLE: noc_ready_out=1. On transfer, latch header fields; len_rem := header[29:22].
  - len_rem==0 -> HOLD.
  - Otherwise -> PAYLOAD; idx := 0.
- PAYLOAD: noc_ready_out=1. On each transfer:
  - if idx<MAX_PAYLOAD, store flit at slot idx;
  - idx++ and len_rem--;
  - when len_rem reaches 0 -> HOLD.
  - Flits beyond MAX_PAYLOAD are consumed and discarded, not stored.
- HOLD: msg_valid=1, noc_ready_out=0.
  - On msg_valid && msg_ready -> IDLE, msg_count++ (saturating at all-ones).
  - The next header is not accepted in the same cycle: one bubble cycle between messages.
- Latency: msg_valid rises the cycle after the last flit transfer. A header-only message therefore shows msg_valid one cycle after the header.
- Payload slots not written by the current message read zero. They are cleared on header capture.
- Outputs stay stable while msg_valid=1 and msg_ready=0.
- noc_ready_out is a registered function of state only; no combinational path from msg_ready.
- Reset (asynchronous, any state, including mid-message):
  - state=IDLE, noc_ready_out=1 after deassertion;
  - msg_valid=0, all msg_* fields=0, msg_count=0, err=0;
  - partial message discarded.
- noc_valid_in while noc_ready_out=0: ignored, no state change.

Optional Feature:
- Macro NOC2_DEFRAMER_ERRCHK_EN.
- When defined:
  - a header with msg_len > MAX_PAYLOAD sets err sticky; its flits are still consumed to keep the NoC aligned;
  - msg_type==0 in a header sets err;
  - err clears only on rst.
- When undefined:
  - err is tied to 0;
  - oversize payloads are silently truncated to MAX_PAYLOAD stored flits.

Decomposition:
- Shared package l2_noc_pkg holds:
  - header bit-position constants (CHIPID_HI/LO, X_HI/LO, Y_HI/LO, LEN_HI/LO, TYPE_HI/LO, MSHRID_HI/LO);
  - the FSM state enum (IDLE, PAYLOAD, HOLD);
  - NoC2 message-type constants used by the testbench.
- One natural sub-module: noc_hdr_decode, a combinational header field slicer, reused by the NoC1/NoC3 injectors.

Test Plan:
- Header-only message, type 0x12, mshrid 0x05, len 0, msg_ready=1 -> msg_valid=1 one cycle later with msg_type=0x12, msg_mshrid=0x05, msg_len=0; msg_count=1.
- Header with len=2, then flits 0xAAAA…, 0x5555… -> slots 0,1 hold those flits, slots 2..3 zero; msg_valid appears the cycle after the second flit.
- msg_ready=0 for 5 cycles during HOLD -> noc_ready_out=0 throughout, fields stable, a presented flit is not consumed; msg_ready=1 -> IDLE next cycle.
- Back-to-back len=1 messages with continuous noc_valid_in -> both delivered in order, msg_count=2, one bubble cycle between them.
- len=6 with MAX_PAYLOAD=4 -> all 7 flits consumed, first 4 payload flits stored; err=1 with NOC2_DEFRAMER_ERRCHK_EN, err=0 without it.
- Assert rst after the 2nd of 3 flits -> immediate msg_valid=0 and msg_count=0; after release, a fresh len=0 message is delivered correctly.

Source files
------------

// File: rtl/l2_noc_pkg.sv
// Shared NoC2 definitions: header bit positions, deframer FSM states and
// the message-type codes that show up on the L2's NoC2 output.
package l2_noc_pkg;

  // Header field positions within a 64-bit NoC header flit
  localparam int CHIPID_HI = 63;
  localparam int CHIPID_LO = 50;
  localparam int X_HI      = 49;
  localparam int X_LO      = 42;
  localparam int Y_HI      = 41;
  localparam int Y_LO      = 34;
  localparam int LEN_HI    = 29;
  localparam int LEN_LO    = 22;
  localparam int TYPE_HI   = 21;
  localparam int TYPE_LO   = 14;
  localparam int MSHRID_HI = 13;
  localparam int MSHRID_LO = 6;

  // Deframer FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    HOLD    = 2'd2
  } deframer_state_e;

  // NoC2 message types
  localparam logic [7:0] MSG_TYPE_NODATA_ACK = 8'h12;
  localparam logic [7:0] MSG_TYPE_DATA_ACK   = 8'h13;
  localparam logic [7:0] MSG_TYPE_INV_FWD    = 8'h22;

endpackage

// File: rtl/noc_hdr_decode.sv
// Combinational NoC header field slicer, shared by the NoC deframer and
// the NoC1/NoC3 injectors.
module noc_hdr_decode
  import l2_noc_pkg::*;
#(
  parameter int FLIT_W = 64
) (
  input  logic [FLIT_W-1:0] hdr,
  output logic [13:0]       chipid,
  output logic [7:0]        x,
  output logic [7:0]        y,
  output logic [7:0]        len,
  output logic [7:0]        mtype,
  output logic [7:0]        mshrid
);

  // Reserved header bits carry nothing we decode
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{hdr[LEN_HI+4:LEN_HI+1], hdr[MSHRID_LO-1:0]};

  assign chipid = hdr[CHIPID_HI:CHIPID_LO];
  assign x      = hdr[X_HI:X_LO];
  assign y      = hdr[Y_HI:Y_LO];
  assign len    = hdr[LEN_HI:LEN_LO];
  assign mtype  = hdr[TYPE_HI:TYPE_LO];
  assign mshrid = hdr[MSHRID_HI:MSHRID_LO];

endmodule

// File: rtl/noc2_msg_deframer.sv
// NoC2 message deframer: collects a header flit plus its payload flits into
// one parallel record and holds it on a valid/ready port until consumed.
// The L2 is backpressured while a complete message is held.
// Handshakes: a flit moves when noc_valid_in && noc_ready_out at a rising
// edge; a message moves when msg_valid && msg_ready at a rising edge. Valid
// never waits on ready, and held outputs do not change until the handshake.
// Optional build macro NOC2_DEFRAMER_ERRCHK_EN enables the sticky protocol
// error flag (oversize length or zero message type in a header).
module noc2_msg_deframer
  import l2_noc_pkg::*;
#(
  parameter int FLIT_W      = 64,
  parameter int MAX_PAYLOAD = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          noc_valid_in,
  input  logic [FLIT_W-1:0]             noc_data_in,
  output logic                          noc_ready_out,
  output logic                          msg_valid,
  input  logic                          msg_ready,
  output logic [7:0]                    msg_type,
  output logic [7:0]                    msg_mshrid,
  output logic [7:0]                    msg_len,
  output logic [13:0]                   msg_chipid,
  output logic [7:0]                    msg_x,
  output logic [7:0]                    msg_y,
  output logic [MAX_PAYLOAD*FLIT_W-1:0] msg_payload,
  output logic [CNT_W-1:0]              msg_count,
  output logic                          err,
  output deframer_state_e               dbg_state
);

  deframer_state_e state, state_n;
  logic            rdy_q;
  logic [7:0]      len_rem;
  logic [7:0]      idx;
  logic            xfer;

  logic [13:0] h_chipid;
  logic [7:0]  h_x, h_y, h_len, h_type, h_mshrid;

  noc_hdr_decode #(.FLIT_W(FLIT_W)) u_hdr (
    .hdr    (noc_data_in),
    .chipid (h_chipid),
    .x      (h_x),
    .y      (h_y),
    .len    (h_len),
    .mtype  (h_type),
    .mshrid (h_mshrid)
  );

  assign xfer          = noc_valid_in && rdy_q;
  assign noc_ready_out = rdy_q;
  assign msg_valid     = (state == HOLD);
  assign dbg_state     = state;

  // Next-state: header opens a message, last payload flit closes it
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (xfer) state_n = (h_len == 8'd0) ? HOLD : PAYLOAD;
      PAYLOAD: if (xfer && len_rem == 8'd1) state_n = HOLD;
      HOLD:    if (msg_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; ready is registered from the next state so msg_ready
  // never reaches noc_ready_out combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b1;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != HOLD);
    end
  end

  // Message record: header capture clears payload, payload flits fill slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_type    <= '0;
      msg_mshrid  <= '0;
      msg_len     <= '0;
      msg_chipid  <= '0;
      msg_x       <= '0;
      msg_y       <= '0;
      msg_payload <= '0;
      len_rem     <= '0;
      idx         <= '0;
    end else if (xfer && state == IDLE) begin
      msg_type    <= h_type;
      msg_mshrid  <= h_mshrid;
      msg_len     <= h_len;
      msg_chipid  <= h_chipid;
      msg_x       <= h_x;
      msg_y       <= h_y;
      msg_payload <= '0;
      len_rem     <= h_len;
      idx         <= '0;
    end else if (xfer && state == PAYLOAD) begin
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        if (idx == 8'(i)) msg_payload[i*FLIT_W +: FLIT_W] <= noc_data_in;
      end
      idx     <= idx + 8'd1;
      len_rem <= len_rem - 8'd1;
    end
  end

  // Delivered-message counter, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_count <= '0;
    end else if (state == HOLD && msg_ready && msg_count != {CNT_W{1'b1}}) begin
      msg_count <= msg_count + 1'b1;
    end
  end

`ifdef NOC2_DEFRAMER_ERRCHK_EN
  logic err_q;

  // Sticky error on a bad header; the message is still consumed in full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (xfer && state == IDLE &&
                 (h_len > 8'(MAX_PAYLOAD) || h_type == 8'd0)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_noc2_msg_deframer.sv
// Self-checking bench for noc2_msg_deframer: directed scenarios with literal
// expectations, then randomized traffic against a message-level model.
module tb_noc2_msg_deframer;
  import l2_noc_pkg::*;

  localparam int FLIT_W      = 64;
  localparam int MAX_PAYLOAD = 4;
  localparam int CNT_W       = 16;
  localparam int PW          = MAX_PAYLOAD * FLIT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  noc_valid_in = 1'b0;
  logic [FLIT_W-1:0]     noc_data_in  = '0;
  logic                  noc_ready_out;
  logic                  msg_valid;
  logic                  msg_ready = 1'b0;
  logic [7:0]            msg_type, msg_mshrid, msg_len, msg_x, msg_y;
  logic [13:0]           msg_chipid;
  logic [PW-1:0]         msg_payload;
  logic [CNT_W-1:0]      msg_count;
  logic                  err;
  deframer_state_e       dbg_state;

  noc2_msg_deframer #(.FLIT_W(FLIT_W), .MAX_PAYLOAD(MAX_PAYLOAD), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .noc_valid_in  (noc_valid_in),
    .noc_data_in   (noc_data_in),
    .noc_ready_out (noc_ready_out),
    .msg_valid     (msg_valid),
    .msg_ready     (msg_ready),
    .msg_type      (msg_type),
    .msg_mshrid    (msg_mshrid),
    .msg_len       (msg_len),
    .msg_chipid    (msg_chipid),
    .msg_x         (msg_x),
    .msg_y         (msg_y),
    .msg_payload   (msg_payload),
    .msg_count     (msg_count),
    .err           (err),
    .dbg_state     (dbg_state)
  );

`ifdef NOC2_DEFRAMER_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [FLIT_W-1:0] stim_q[$];   // flits still to be offered to the DUT
  logic [FLIT_W-1:0] exp_q[$];    // flits of the message being assembled
  logic [CNT_W-1:0]  m_count = '0;
  logic              m_err   = 1'b0;
  int vprob = 100;
  int rprob = 100;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_hdr(input logic [13:0] chipid, input logic [7:0] x,
      input logic [7:0] y, input logic [7:0] len, input logic [7:0] mtype, input logic [7:0] mshrid);
    return {chipid, x, y, 4'h0, len, mtype, mshrid, 6'h0};
  endfunction

  // A message is complete once its header and all announced payload flits arrived
  function automatic bit m_complete();
    logic [FLIT_W-1:0] h;
    logic [7:0] l;
    if (exp_q.size() == 0) return 1'b0;
    h = exp_q[0];
    l = h[LEN_HI:LEN_LO];
    return exp_q.size() == 1 + int'(l);
  endfunction

  function automatic logic [PW-1:0] exp_payload();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++)
      if (i + 1 < exp_q.size()) p[i*FLIT_W +: FLIT_W] = exp_q[i+1];
    return p;
  endfunction

  // Compare DUT outputs with the model
  task automatic compare();
    logic [FLIT_W-1:0] h;
    check("ready", noc_ready_out, !m_complete());
    check("valid", msg_valid, m_complete());
    check("count", msg_count, m_count);
    check("err", err, m_err);
    if (m_complete()) begin
      h = exp_q[0];
      check("type", msg_type, h[TYPE_HI:TYPE_LO]);
      check("mshrid", msg_mshrid, h[MSHRID_HI:MSHRID_LO]);
      check("len", msg_len, h[LEN_HI:LEN_LO]);
      check("chipid", msg_chipid, h[CHIPID_HI:CHIPID_LO]);
      check("x", msg_x, h[X_HI:X_LO]);
      check("y", msg_y, h[Y_HI:Y_LO]);
      check("payload", msg_payload, exp_payload());
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: compare at the falling edge, drive new inputs, advance the
  // model by what the following rising edge must do.
  task automatic step();
    logic [FLIT_W-1:0] f;
    logic [7:0] l, t;
    @(negedge clk);
    compare();
    noc_valid_in = (stim_q.size() > 0) && ($urandom_range(99) < vprob);
    noc_data_in  = (stim_q.size() > 0) ? stim_q[0] : '0;
    msg_ready    = ($urandom_range(99) < rprob);
    if (m_complete()) begin
      if (msg_ready) begin
        if (m_count != {CNT_W{1'b1}}) m_count++;
        exp_q.delete();
      end
    end else if (noc_valid_in) begin
      f = stim_q.pop_front();
      if (exp_q.size() == 0) begin
        l = f[LEN_HI:LEN_LO];
        t = f[TYPE_HI:TYPE_LO];
        if (ERRCHK && (int'(l) > MAX_PAYLOAD || t == 8'd0)) m_err = 1'b1;
      end
      exp_q.push_back(f);
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    noc_valid_in = 1'b0;
    msg_ready = 1'b0;
    #1;
    check("rst_valid", msg_valid, 1'b0);
    check("rst_count", msg_count, '0);
    check("rst_type", msg_type, '0);
    check("rst_payload", msg_payload, '0);
    check("rst_err", err, 1'b0);
    exp_q.delete();
    stim_q.delete();
    m_count = '0;
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_random_msg();
    logic [7:0] l, t;
    l = 8'($urandom_range(0, 6));
    t = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    stim_q.push_back(mk_hdr(14'($urandom), 8'($urandom), 8'($urandom), l, t, 8'($urandom)));
    for (int i = 0; i < int'(l); i++) stim_q.push_back({$urandom, $urandom});
  endtask

  // ---------------- test sequence ----------------
  logic [5:0] vpat;
  initial begin
    repeat (2) @(negedge clk);
    check("reset_ready", noc_ready_out, 1'b1);
    check("reset_valid", msg_valid, 1'b0);
    check("reset_count", msg_count, '0);
    check("reset_err", err, 1'b0);
    check("reset_payload", msg_payload, '0);
    rst = 1'b0;

    // header-only message
    vprob = 100; rprob = 100;
    stim_q.push_back(mk_hdr(14'h0001, 8'h02, 8'h03, 8'd0, MSG_TYPE_NODATA_ACK, 8'h05));
    step();
    step();
    check("t1_valid", msg_valid, 1'b1);
    check("t1_type", msg_type, 8'h12);
    check("t1_mshrid", msg_mshrid, 8'h05);
    check("t1_len", msg_len, 8'd0);
    step();
    check("t1_count", msg_count, 16'd1);

    // two payload flits, then hold under backpressure
    rprob = 0;
    stim_q.push_back(mk_hdr(14'h0100, 8'h10, 8'h20, 8'd2, MSG_TYPE_DATA_ACK, 8'h33));
    stim_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    stim_q.push_back(64'h5555_5555_5555_5555);
    repeat (3) step();
    check("t2_valid_lat", msg_valid, 1'b0);
    step();
    check("t2_valid", msg_valid, 1'b1);
    check("t2_slot0", msg_payload[0 +: FLIT_W], 64'hAAAA_AAAA_AAAA_AAAA);
    check("t2_slot1", msg_payload[FLIT_W +: FLIT_W], 64'h5555_5555_5555_5555);
    check("t2_slot23", msg_payload[2*FLIT_W +: 2*FLIT_W], '0);
    stim_q.push_back(mk_hdr(14'h0002, 8'h01, 8'h01, 8'd0, MSG_TYPE_INV_FWD, 8'h44));
    repeat (5) begin
      step();
      check("t3_hold_ready", noc_ready_out, 1'b0);
      check("t3_hold_slot1", msg_payload[FLIT_W +: FLIT_W], 64'h5555_5555_5555_5555);
    end
    rprob = 100;
    step();
    step();
    check("t3_idle_ready", noc_ready_out, 1'b1);
    check("t3_idle_valid", msg_valid, 1'b0);
    repeat (3) step();

    // back-to-back len=1 messages
    stim_q.push_back(mk_hdr(14'h0003, 8'h04, 8'h05, 8'd1, MSG_TYPE_DATA_ACK, 8'h01));
    stim_q.push_back(64'h1111_2222_3333_4444);
    stim_q.push_back(mk_hdr(14'h0006, 8'h07, 8'h08, 8'd1, MSG_TYPE_DATA_ACK, 8'h02));
    stim_q.push_back(64'h5555_6666_7777_8888);
    for (int k = 0; k < 6; k++) begin
      step();
      vpat[k] = msg_valid;
    end
    check("t4_valid_pattern", vpat, 6'b100100);
    step();
    check("t4_count", msg_count, 16'd5);

    // oversize message: all flits consumed, four stored
    rprob = 0;
    stim_q.push_back(mk_hdr(14'h0009, 8'h0A, 8'h0B, 8'd6, MSG_TYPE_DATA_ACK, 8'h06));
    for (int i = 1; i <= 6; i++) stim_q.push_back(64'(i));
    repeat (8) step();
    check("t5_valid", msg_valid, 1'b1);
    for (int i = 0; i < MAX_PAYLOAD; i++)
      check("t5_slot", msg_payload[i*FLIT_W +: FLIT_W], 64'(i + 1));
    check("t5_err", err, ERRCHK);
    rprob = 100;
    repeat (2) step();

    // reset in the middle of a message
    stim_q.push_back(mk_hdr(14'h000C, 8'h0D, 8'h0E, 8'd2, MSG_TYPE_INV_FWD, 8'h09));
    stim_q.push_back(64'hDEAD_BEEF_0000_0001);
    stim_q.push_back(64'hDEAD_BEEF_0000_0002);
    repeat (2) step();
    do_reset_mid();
    stim_q.push_back(mk_hdr(14'h0001, 8'h00, 8'h00, 8'd0, MSG_TYPE_NODATA_ACK, 8'h07));
    step();
    step();
    check("t6_valid", msg_valid, 1'b1);
    check("t6_type", msg_type, 8'h12);
    check("t6_mshrid", msg_mshrid, 8'h07);
    step();
    check("t6_count", msg_count, 16'd1);

    // randomized traffic
    vprob = 70; rprob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (stim_q.size() < 2) push_random_msg();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
